// File: rtl/bch_pkg.sv
// Shared GF(2^m) helpers for the BCH datapath (syndrome, BM and Chien blocks).
// All functions are evaluated at elaboration to build constant XOR matrices.
package bch_pkg;

    localparam int C_MAX_M = 16;
    localparam logic [5:0] C_PRIM_POLY_DEFAULT = 6'h25;

    typedef logic [C_MAX_M-1:0] gf_elem_t;
    // Column b holds alpha^e * alpha^b, so a product is the XOR of columns
    // selected by the set bits of the multiplicand.
    typedef logic [C_MAX_M-1:0][C_MAX_M-1:0] gf_mat_t;

    function automatic gf_elem_t f_alpha_pow(input int m, input logic [31:0] poly, input int e);
        logic [C_MAX_M:0] v;
        int n;
        v = '0;
        v[0] = 1'b1;
        n = e % ((1 << m) - 1);
        for (int i = 0; i < n; i++) begin
            v = v << 1;
            if ((v >> m) != '0)
                v = v ^ poly[C_MAX_M:0];
        end
        return v[C_MAX_M-1:0];
    endfunction

    function automatic gf_mat_t f_const_mult_matrix(input int m, input logic [31:0] poly, input int e);
        gf_mat_t mat;
        mat = '0;
        for (int b = 0; b < m; b++)
            mat = mat | (gf_mat_t'(f_alpha_pow(m, poly, e + b)) << (b * C_MAX_M));
        return mat;
    endfunction

endpackage

// File: rtl/bch_syn_lane.sv
// One odd-syndrome accumulator S(C_J): Horner step by alpha^(C_J*C_PAR) plus
// the constant feed-in of a C_PAR-bit beat.
module bch_syn_lane
    import bch_pkg::*;
#(
    parameter int C_M   = 5,
    parameter int C_PAR = 4,
    parameter int C_J   = 1,
    parameter logic [C_M:0] C_PRIM_POLY = C_PRIM_POLY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             first,
    input  logic [C_PAR-1:0] data,
    output logic [C_M-1:0]   acc_nxt
);

    localparam gf_mat_t C_MAT = f_const_mult_matrix(C_M, 32'(C_PRIM_POLY), C_J * C_PAR);

    logic [C_M-1:0]         acc;
    logic [C_M:0][C_M-1:0]  shift_sum;
    logic [C_PAR:0][C_M-1:0] feed_sum;

    assign shift_sum[0] = '0;
    assign feed_sum[0]  = '0;

    for (genvar b = 0; b < C_M; b++) begin : g_shift
        localparam gf_elem_t C_COL = C_MAT[b];
        assign shift_sum[b+1] = shift_sum[b] ^ (acc[b] ? C_COL[C_M-1:0] : '0);
    end

    // Coefficient k of the beat sits at alpha^(C_J*k) relative to the beat's lowest degree.
    for (genvar k = 0; k < C_PAR; k++) begin : g_feed
        localparam gf_elem_t C_FEED = f_alpha_pow(C_M, 32'(C_PRIM_POLY), C_J * k);
        assign feed_sum[k+1] = feed_sum[k] ^ (data[k] ? C_FEED[C_M-1:0] : '0);
    end

    assign acc_nxt = (first ? '0 : shift_sum[C_M]) ^ feed_sum[C_PAR];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/bch_syndrome_seq.sv
// Streaming BCH syndrome engine: C_PAR codeword bits per beat, highest degree
// first, odd syndromes S1..S(2t-1) held in output registers until consumed.
module bch_syndrome_seq
    import bch_pkg::*;
#(
    parameter int C_M       = 5,
    parameter int C_N       = 31,
    parameter int C_ERR_NUM = 4,
    parameter int C_PAR     = 4,
    parameter logic [C_M:0] C_PRIM_POLY = C_PRIM_POLY_DEFAULT
) (
    input  logic                       I_clk,
    input  logic                       I_rst,
    input  logic                       I_clear,
    input  logic                       I_valid,
    output logic                       O_ready,
    input  logic [C_PAR-1:0]           I_data,
    output logic                       O_syn_valid,
    input  logic                       I_syn_ready,
    output logic [C_M*C_ERR_NUM-1:0]   O_syndromes,
    output logic                       O_correct
);

    localparam int C_B  = (C_N + C_PAR - 1) / C_PAR;
    localparam int C_R  = C_N - (C_B - 1) * C_PAR;
    localparam int C_CW = (C_B > 1) ? $clog2(C_B) : 1;
    localparam logic [C_CW-1:0]  C_LAST       = C_CW'(C_B - 1);
    localparam logic [C_PAR-1:0] C_FIRST_MASK = {C_PAR{1'b1}} >> (C_PAR - C_R);

    logic [C_CW-1:0]                 cnt;
    logic                            first;
    logic                            last;
    logic                            accept;
    logic [C_PAR-1:0]                beat;
    logic [C_ERR_NUM-1:0][C_M-1:0]   syn_nxt;

    assign first   = (cnt == '0);
    assign last    = (cnt == C_LAST);
    // Only a final beat can collide with an unconsumed result.
    assign O_ready = !(last && O_syn_valid && !I_syn_ready);
    assign accept  = I_valid && O_ready && !I_clear;
    assign beat    = first ? (I_data & C_FIRST_MASK) : I_data;

    for (genvar i = 0; i < C_ERR_NUM; i++) begin : g_lane
        bch_syn_lane #(
            .C_M         (C_M),
            .C_PAR       (C_PAR),
            .C_J         (2 * i + 1),
            .C_PRIM_POLY (C_PRIM_POLY)
        ) u_lane (
            .clk     (I_clk),
            .rst     (I_rst),
            .en      (accept),
            .first   (first),
            .data    (beat),
            .acc_nxt (syn_nxt[i])
        );
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt         <= '0;
            O_syn_valid <= 1'b0;
            O_syndromes <= '0;
            O_correct   <= 1'b0;
        end else begin
            if (I_clear)
                cnt <= '0;
            else if (accept)
                cnt <= last ? '0 : cnt + C_CW'(1);

            if (accept && last) begin
                O_syndromes <= syn_nxt;
                O_correct   <= (syn_nxt == '0);
                O_syn_valid <= 1'b1;
            end else if (O_syn_valid && I_syn_ready) begin
                O_syn_valid <= 1'b0;
            end
        end
    end

endmodule
